// File: rtl/fp_issue_seq.sv
// fp_issue_seq: streams a program from synchronous memory into an FPU,
// keeping at most MAX_OUT instructions in flight and retiring results in order.
module fp_issue_seq #(
  parameter int MAX_OUT = 4,
  parameter int AW      = 5
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          start_i,
  input  logic [AW:0]   prog_len_i,
  output logic [AW-1:0] mem_addr_o,
  input  logic [31:0]   mem_data_i,
  output logic [31:0]   instr_o,
  output logic          in_valid_o,
  input  logic          in_ready_i,
  input  logic [31:0]   result_i,
  input  logic          out_valid_i,
  output logic          out_ready_o,
  output logic          res_valid_o,
  output logic [31:0]   res_data_o,
  output logic [AW-1:0] res_idx_o,
  output logic          done_o,
  output logic          err_o,
  output logic          busy_o
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_ISSUE, S_DRAIN, S_DONE
  } state_t;

  localparam logic [AW:0] LP_MAX = MAX_OUT[AW:0];
  localparam logic [AW:0] LP_ONE = {{AW{1'b0}}, 1'b1};

  state_t        r_state;
  logic [AW:0]   r_len;
  logic [AW:0]   r_issued;
  logic [AW:0]   r_retired;
  logic [AW-1:0] r_addr;
  logic [31:0]   r_instr;
  logic          r_load;
  logic          r_res_valid;
  logic [31:0]   r_res_data;
  logic [AW-1:0] r_res_idx;
  logic          r_done;
  logic          r_err;

  logic [AW:0] w_outst;
  logic [AW:0] w_iss_nx;
  logic        w_in_valid;
  logic        w_out_ready;
  logic        w_in_hs;
  logic        w_out_hs;

  assign w_outst     = r_issued - r_retired;
  assign w_iss_nx    = r_issued + LP_ONE;
  assign w_in_valid  = (r_state == S_ISSUE) && (w_outst < LP_MAX);
  assign w_out_ready = (r_state == S_FETCH) || (r_state == S_ISSUE) ||
                       (r_state == S_DRAIN);
  assign w_in_hs     = w_in_valid && in_ready_i;
  assign w_out_hs    = out_valid_i && w_out_ready;

  // Read data lands in the first ISSUE cycle: forward it, then hold the copy.
  assign instr_o     = r_load ? mem_data_i : r_instr;
  assign mem_addr_o  = r_addr;
  assign in_valid_o  = w_in_valid;
  assign out_ready_o = w_out_ready;
  assign res_valid_o = r_res_valid;
  assign res_data_o  = r_res_data;
  assign res_idx_o   = r_res_idx;
  assign done_o      = r_done;
  assign err_o       = r_err;
  assign busy_o      = (r_state != S_IDLE);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_issued    <= '0;
      r_retired   <= '0;
      r_addr      <= '0;
      r_instr     <= '0;
      r_load      <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_data  <= '0;
      r_res_idx   <= '0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_res_valid <= 1'b0;
      r_done      <= 1'b0;
      r_load      <= 1'b0;
      if (r_load)
        r_instr <= mem_data_i;
      // A result with nothing in flight cannot belong to any instruction.
      if (w_out_hs) begin
        if (w_outst == '0) begin
          r_err <= 1'b1;
        end else begin
          r_res_valid <= 1'b1;
          r_res_data  <= result_i;
          r_res_idx   <= r_retired[AW-1:0];
          r_retired   <= r_retired + LP_ONE;
        end
      end
      unique case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_len     <= prog_len_i;
            r_issued  <= '0;
            r_retired <= '0;
            r_err     <= 1'b0;
            r_addr    <= '0;
            r_state   <= (prog_len_i == '0) ? S_DONE : S_FETCH;
          end
        end
        S_FETCH: begin
          r_load  <= 1'b1;
          r_state <= S_ISSUE;
        end
        S_ISSUE: begin
          if (w_in_hs) begin
            r_issued <= w_iss_nx;
            if (w_iss_nx == r_len) begin
              r_state <= S_DRAIN;
            end else begin
              r_addr  <= r_addr + 1'b1;
              r_state <= S_FETCH;
            end
          end
        end
        S_DRAIN: begin
          if (r_retired == r_len)
            r_state <= S_DONE;
        end
        S_DONE: begin
          r_done  <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_issue_seq.sv
// tb_fp_issue_seq: directed vector table plus hand sequences for the
// fp_issue_seq program sequencer, with a behavioural memory and FPU.
`timescale 1ns/1ps
module tb_fp_issue_seq;

  localparam int AW = 5;
  localparam int MO = 4;
  localparam logic [31:0] K = 32'h5A5A_5A5A;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   prog_len;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_q;
  logic [31:0]   instr;
  logic          in_valid;
  logic          in_ready;
  logic [31:0]   result;
  logic          out_valid;
  logic          out_ready;
  logic          res_valid;
  logic [31:0]   res_data;
  logic [AW-1:0] res_idx;
  logic          done;
  logic          err;
  logic          busy;

  logic [31:0] mem [32];
  int n_chk = 0;
  int n_fail = 0;

  fp_issue_seq #(.MAX_OUT(MO), .AW(AW)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start), .prog_len_i(prog_len),
    .mem_addr_o(mem_addr), .mem_data_i(mem_q), .instr_o(instr),
    .in_valid_o(in_valid), .in_ready_i(in_ready), .result_i(result),
    .out_valid_i(out_valid), .out_ready_o(out_ready),
    .res_valid_o(res_valid), .res_data_o(res_data), .res_idx_o(res_idx),
    .done_o(done), .err_o(err), .busy_o(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem_q <= mem[mem_addr];

  typedef struct {
    int   len;
    int   stall;
    int   lat;
    int   exp_iss;
    int   exp_ret;
    int   exp_last;
    logic exp_err;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run(input vec_t v, input string nm);
    int cyc = 0;
    int iss = 0;
    int ret = 0;
    int pops = 0;
    int dones = 0;
    int last = -1;
    logic pv = 1'b0;
    logic pr = 1'b0;
    logic [31:0] pi = '0;
    logic [31:0] qd[$];
    int qt[$];
    @(negedge clk);
    start = 1'b1;
    prog_len = v.len[AW:0];
    in_ready = 1'b0;
    out_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
    while (dones == 0 && cyc < 600) begin
      if (res_valid) begin
        chk({nm, ".idx"}, 64'(res_idx), 64'(ret[AW-1:0]));
        chk({nm, ".data"}, 64'(res_data), 64'(mem[ret] ^ K));
        last = ret;
        ret++;
      end
      if (done) begin
        dones++;
      end else begin
        if (pv && !pr) begin
          chk({nm, ".hold_v"}, 64'(in_valid), 64'(1));
          chk({nm, ".hold_i"}, 64'(instr), 64'(pi));
        end
        in_ready = (cyc >= v.stall);
        if (in_valid && in_ready) begin
          chk({nm, ".instr"}, 64'(instr), 64'(mem[iss]));
          chk({nm, ".limit"}, 64'((iss - pops) < MO), 64'(1));
          qd.push_back(instr ^ K);
          qt.push_back(cyc + v.lat);
          iss++;
        end
        out_valid = 1'b0;
        if (qd.size() > 0 && qt[0] <= cyc) begin
          out_valid = 1'b1;
          result = qd[0];
        end
        if (out_valid && out_ready) begin
          void'(qd.pop_front());
          void'(qt.pop_front());
          pops++;
        end
        pv = in_valid;
        pr = in_ready;
        pi = instr;
        @(negedge clk);
        cyc++;
      end
    end
    in_ready = 1'b0;
    out_valid = 1'b0;
    chk({nm, ".done"}, 64'(dones), 64'(1));
    chk({nm, ".issues"}, 64'(iss), 64'(v.exp_iss));
    chk({nm, ".retired"}, 64'(ret), 64'(v.exp_ret));
    chk({nm, ".err"}, 64'(err), 64'(v.exp_err));
    chk({nm, ".busy"}, 64'(busy), 64'(0));
    if (v.exp_ret > 0)
      chk({nm, ".last"}, 64'(last), 64'(v.exp_last));
    @(negedge clk);
    chk({nm, ".pulse"}, 64'(done), 64'(0));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".addr"}, 64'(mem_addr), 64'(0));
    chk({nm, ".instr"}, 64'(instr), 64'(0));
    chk({nm, ".rdata"}, 64'(res_data), 64'(0));
    chk({nm, ".ctl"},
        64'({in_valid, out_ready, res_valid, res_idx, done, err, busy}),
        64'(0));
  endtask

  vec_t tbl[6];

  initial begin
    int cnt;
    logic got;
    for (int i = 0; i < 32; i++)
      mem[i] = 32'h3F80_0000 + i * 32'h0001_0103;
    tbl = '{
      '{3,  0, 2, 3,  3,  2,  1'b0},
      '{2,  5, 1, 2,  2,  1,  1'b0},
      '{0,  0, 1, 0,  0,  0,  1'b0},
      '{32, 0, 3, 32, 32, 31, 1'b0},
      '{5,  2, 9, 5,  5,  4,  1'b0},
      '{4,  0, 1, 4,  4,  3,  1'b0}
    };
    rst = 1'b1;
    start = 1'b0;
    prog_len = '0;
    in_ready = 1'b0;
    out_valid = 1'b0;
    result = '0;
    @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 6; i++)
      run(tbl[i], $sformatf("vec%0d", i));

    // len=0: DONE state, then the done pulse two cycles after start
    @(negedge clk);
    start = 1'b1;
    prog_len = '0;
    @(negedge clk);
    start = 1'b0;
    chk("len0.d1", 64'({done, busy, in_valid}), 64'(3'b010));
    @(negedge clk);
    chk("len0.d2", 64'({done, busy, in_valid}), 64'(3'b100));
    @(negedge clk);
    chk("len0.d3", 64'(done), 64'(0));

    // outstanding limit with no results returned
    start = 1'b1;
    prog_len = 6'd6;
    in_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (in_valid) cnt++;
      @(negedge clk);
    end
    chk("lim.count", 64'(cnt), 64'(4));
    chk("lim.stall", 64'(in_valid), 64'(0));
    out_valid = 1'b1;
    result = 32'h1234_5678;
    @(negedge clk);
    out_valid = 1'b0;
    chk("lim.res", 64'({res_valid, res_idx}), 64'({1'b1, 5'd0}));
    chk("lim.rdata", 64'(res_data), 64'(32'h1234_5678));
    got = 1'b0;
    for (int i = 0; i < 6 && !got; i++) begin
      if (in_valid) begin
        got = 1'b1;
        chk("lim.instr5", 64'(instr), 64'(mem[4]));
      end
      @(negedge clk);
    end
    chk("lim.fifth", 64'(got), 64'(1));
    in_ready = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // result pulse in IDLE is ignored
    out_valid = 1'b1;
    result = 32'hDEAD_BEEF;
    chk("idle.ordy", 64'(out_ready), 64'(0));
    @(negedge clk);
    out_valid = 1'b0;
    chk("idle.noeff", 64'({res_valid, err}), 64'(0));

    // spurious result in DRAIN after everything retired
    start = 1'b1;
    prog_len = 6'd1;
    in_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!in_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("sp.issue", 64'(in_valid), 64'(1));
    @(negedge clk);
    in_ready = 1'b0;
    out_valid = 1'b1;
    result = mem[0] ^ K;
    @(negedge clk);
    chk("sp.res", 64'(res_valid), 64'(1));
    result = 32'hDEAD_0001;
    @(negedge clk);
    out_valid = 1'b0;
    chk("sp.err", 64'(err), 64'(1));
    chk("sp.drop", 64'(res_valid), 64'(0));
    @(negedge clk);
    chk("sp.done", 64'(done), 64'(1));
    chk("sp.sticky", 64'(err), 64'(1));
    run('{2, 0, 1, 2, 2, 1, 1'b0}, "clr");

    // reset in the middle of ISSUE
    @(negedge clk);
    start = 1'b1;
    prog_len = 6'd4;
    in_ready = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    in_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst.pre", 64'({in_valid, mem_addr}), 64'({1'b1, 5'd1}));
    #2 rst = 1'b1;
    #1 chk_zero("rst.mid");
    @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    for (int i = 0; i < 5; i++) begin
      if (done || busy) cnt++;
      @(negedge clk);
    end
    chk("rst.nodone", 64'(cnt), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
